// File: rtl/rtn_ch_rsp_queue.sv
// Per-channel response queue on the return crossbar: DEPTH-entry FIFO of {data, bank, rob}
// with a registered occupancy, per-bank pop counters and an occupancy high-water mark.
module rtn_ch_rsp_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [127:0]               in_data,
  input  logic [1:0]                 in_bank_id,
  input  logic [ROB_W-1:0]           in_rob_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [127:0]               out_data,
  output logic [1:0]                 out_bank_id,
  output logic [ROB_W-1:0]           out_rob_id,
  output logic [$clog2(DEPTH):0]     occupancy,
  input  logic                       clr_stats,
  output logic [31:0]                bank_rsp_cnt,
  output logic [$clog2(DEPTH):0]     hwm
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 130 + ROB_W;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_occ;
  logic [PW-1:0] r_hwm;
  logic [7:0]    r_cnt [4];

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic [PW-1:0] w_occ_nxt;
  logic [EW-1:0] w_head;

  assign w_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_push     = in_valid && !w_full;
  assign w_pop      = !w_empty && out_ready;
  assign w_wptr_nxt = r_wptr + PW'(w_push);
  assign w_rptr_nxt = r_rptr + PW'(w_pop);
  assign w_occ_nxt  = w_wptr_nxt - w_rptr_nxt;
  assign w_head     = r_mem[r_rptr[AW-1:0]];

  assign in_ready    = !w_full;
  assign out_valid   = !w_empty;
  assign out_data    = w_head[EW-1 -: 128];
  assign out_bank_id = w_head[ROB_W +: 2];
  assign out_rob_id  = w_head[ROB_W-1:0];
  assign occupancy   = r_occ;
  assign hwm         = r_hwm;

  always_comb begin
    bank_rsp_cnt = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      bank_rsp_cnt[8*b +: 8] = r_cnt[b];
    end
  end

  // Storage is deliberately unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {in_data, in_bank_id, in_rob_id};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      r_occ  <= w_occ_nxt;
    end
  end

  // Clear wins over both the hwm update and a pop landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hwm <= '0;
      for (int unsigned b = 0; b < 4; b++) begin
        r_cnt[b] <= '0;
      end
    end else if (clr_stats) begin
      r_hwm <= '0;
      for (int unsigned b = 0; b < 4; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      if (w_occ_nxt > r_hwm) begin
        r_hwm <= w_occ_nxt;
      end
      if (w_pop && (r_cnt[out_bank_id] != 8'hFF)) begin
        r_cnt[out_bank_id] <= r_cnt[out_bank_id] + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rtn_ch_rsp_queue.sv
// Directed bench for rtn_ch_rsp_queue: inputs driven and outputs sampled on the falling edge.
module tb_rtn_ch_rsp_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ROB_W = 6;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_data;
  logic [1:0]        in_bank_id;
  logic [ROB_W-1:0]  in_rob_id;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_data;
  logic [1:0]        out_bank_id;
  logic [ROB_W-1:0]  out_rob_id;
  logic [2:0]        occupancy;
  logic              clr_stats;
  logic [31:0]       bank_rsp_cnt;
  logic [2:0]        hwm;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  rtn_ch_rsp_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_bank_id   (in_bank_id),
    .in_rob_id    (in_rob_id),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_bank_id  (out_bank_id),
    .out_rob_id   (out_rob_id),
    .occupancy    (occupancy),
    .clr_stats    (clr_stats),
    .bank_rsp_cnt (bank_rsp_cnt),
    .hwm          (hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned pops;
    logic        w_rdy;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bank_id = '0; in_rob_id = '0;
    out_ready = 1'b0; clr_stats = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_hwm", hwm, 0);
    chk("rst_cnt", bank_rsp_cnt, 0);

    // single response
    rst = 1'b0;
    in_valid = 1'b1; in_data = {16{8'hA5}}; in_bank_id = 2'd2; in_rob_id = 6'd5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, {16{8'hA5}});
    chk("single_bank", out_bank_id, 2);
    chk("single_rob", out_rob_id, 5);
    chk("single_occ1", occupancy, 1);
    step();
    chk("single_occ0", occupancy, 0);
    chk("single_cnt", bank_rsp_cnt, 32'h0001_0000);
    chk("single_empty", out_valid, 0);
    chk("single_hwm", hwm, 1);

    // fill and backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_bank_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_rob_id = ROB_W'(i); in_data = 128'(i);
      step();
    end
    chk("fill_in_ready", in_ready, 0);
    chk("fill_occ", occupancy, 4);
    chk("fill_hwm", hwm, 4);
    in_rob_id = 6'd4; in_data = 128'd4;
    step();
    step();
    chk("fill_held_occ", occupancy, 4);
    chk("fill_head", out_rob_id, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_rob", out_rob_id, k);
      chk("drain_data", out_data, k);
      w_rdy = in_ready;
      step();
      if (w_rdy) in_valid = 1'b0;
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_occ", occupancy, 0);
    chk("drain_cnt", bank_rsp_cnt, 32'h0001_0005);

    // simultaneous push/pop at occupancy 2, pointers wrap
    out_ready = 1'b0; in_valid = 1'b1; in_bank_id = 2'd3;
    in_rob_id = 6'd10; step();
    in_rob_id = 6'd11; step();
    chk("pp_pre_occ", occupancy, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_rob_id = ROB_W'(12 + i);
      chk("pp_rob", out_rob_id, 10 + i);
      step();
      chk("pp_occ", occupancy, 2);
    end
    in_valid = 1'b0;
    chk("pp_tail0", out_rob_id, 20);
    step();
    chk("pp_tail1", out_rob_id, 21);
    step();
    chk("pp_occ_end", occupancy, 0);
    chk("pp_cnt", bank_rsp_cnt, 32'h0C01_0005);

    // saturation and clear with concurrent pop
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    chk("clr0_cnt", bank_rsp_cnt, 0);
    chk("clr0_hwm", hwm, 0);
    in_valid = 1'b1; in_bank_id = 2'd1; in_rob_id = 6'd1; out_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 400 && pops < 300; c++) begin
      if (out_valid) pops++;
      step();
    end
    in_valid = 1'b0;
    chk("sat_pops", pops, 300);
    chk("sat_cnt", bank_rsp_cnt, 32'h0000_FF00);
    chk("sat_valid", out_valid, 1);
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    chk("clr1_cnt", bank_rsp_cnt, 0);
    chk("clr1_hwm", hwm, 0);
    chk("clr1_occ", occupancy, 0);

    // stall stability while upstream keeps pushing
    out_ready = 1'b0; in_valid = 1'b1; in_bank_id = 2'd0; in_rob_id = 6'd30; in_data = {4{32'hC0DE_0030}};
    step();
    for (int i = 0; i < 5; i++) begin
      in_rob_id = ROB_W'(31 + i); in_data = 128'(31 + i); in_bank_id = 2'd2;
      chk("stall_rob", out_rob_id, 30);
      chk("stall_data", out_data, {4{32'hC0DE_0030}});
      chk("stall_bank", out_bank_id, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_occ3", occupancy, 3);
    chk("stall_next", out_rob_id, 31);
    chk("stall_hwm", hwm, 4);

    // asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_hwm", hwm, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_cnt", bank_rsp_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_rob_id = 6'd40; in_bank_id = 2'd1; in_data = 128'h40;
    chk("post_rst_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("post_rst_push_valid", out_valid, 1);
    chk("post_rst_push_rob", out_rob_id, 40);
    chk("post_rst_occ", occupancy, 1);
    chk("post_rst_cnt", bank_rsp_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtn_ch_rsp_queue.md
RTN_CH_RSP_QUEUE -- requirements
Module: rtn_ch_rsp_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of 2 and at least 2.
REQ-002 Parameter ROB_W, default 6, rob_id width.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port in_valid, input, 1, response offered by one return-crossbar channel output.
REQ-006 Port in_ready, output, 1, queue accepts the offered response.
REQ-007 Port in_data, input, 128, response data.
REQ-008 Port in_bank_id, input, 2, source bank.
REQ-009 Port in_rob_id, input, ROB_W, ROB tag.
REQ-010 Port out_valid, output, 1, head entry present to the channel consumer.
REQ-011 Port out_ready, input, 1, consumer takes the head entry.
REQ-012 Port out_data / out_bank_id / out_rob_id, output, 128 / 2 / ROB_W, head entry fields.
REQ-013 Port occupancy, output, log2(DEPTH)+1, entries currently held.
REQ-014 Port clr_stats, input, 1, synchronous clear of the statistics counters.
REQ-015 Port bank_rsp_cnt, output, 4x8 packed, [8b+7:8b] = pops from bank b.
REQ-016 Port hwm, output, log2(DEPTH)+1, high-water mark of occupancy.

Function
REQ-017 The block SHALL be a DEPTH-entry FIFO with write and read pointers of log2(DEPTH)+1 bits; the MSB is a wrap bit.
- full = low bits equal and MSBs differ.
- empty = pointers equal.
REQ-018 in_ready SHALL equal !full and SHALL NOT depend combinationally on out_ready.
REQ-019 Push SHALL occur when in_valid && in_ready; it writes {data, bank_id, rob_id} at wptr and increments wptr modulo 2*DEPTH.
REQ-020 out_valid SHALL equal !empty; out_* SHALL present the entry at rptr; pop occurs when out_valid && out_ready and increments rptr.
REQ-021 Latency: an entry pushed in cycle N SHALL be visible on out_* no earlier than cycle N+1 (no same-cycle bypass).
REQ-022 Push and pop in the same cycle SHALL both take effect.
- Occupancy is unchanged.
- When full, no push is possible in that cycle because of REQ-018.
REQ-023 Output fields SHALL stay stable while out_valid && !out_ready; in-order delivery SHALL be preserved.
REQ-024 occupancy SHALL equal wptr - rptr (modulo 2*DEPTH) and SHALL be registered-consistent with the pointers.
REQ-025 On each pop, bank_rsp_cnt[out_bank_id] SHALL increment by 1 and saturate at 255.
REQ-026 hwm SHALL load the next-cycle occupancy whenever that value exceeds hwm.
REQ-027 clr_stats SHALL zero all bank counters and hwm next cycle; FIFO contents are unaffected.
- A pop in the same cycle as clr_stats SHALL NOT be counted.
- clr_stats has priority over hwm update.
REQ-028 When in_valid && !in_ready, the upstream is expected to hold its inputs; the queue SHALL ignore them until in_ready rises.

Reset
REQ-029 While rst is high, pointers, occupancy, hwm and all counters SHALL be 0.
- out_valid = 0.
- in_ready = 1.
- Storage contents are don't-care.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately (asynchronous).
- No pop SHALL be reported in the cycle rst deasserts.
- The first push after deassertion SHALL appear at out_* one cycle later.

Verification
REQ-031 Single response: after reset, push data=0xA5..A5, bank=2, rob=5 with out_ready=1 -> out_valid high next cycle with the same fields; bank_rsp_cnt[2]=1; occupancy back to 0.
REQ-032 Fill and backpressure: out_ready=0, push 5 entries back-to-back with DEPTH=4 -> in_ready drops after the 4th push; occupancy=4; hwm=4; 5th held. Then out_ready=1 -> order rob 0,1,2,3,4 with no loss.
REQ-033 Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2; pointers wrap at least once; output order preserved.
REQ-034 Saturation: 300 pops from bank 1 -> bank_rsp_cnt[1]=255, others 0. Then clr_stats with a concurrent pop -> all counters 0 the next cycle.
REQ-035 Reset mid-stream: occupancy=3, assert rst for 1 cycle -> out_valid=0, occupancy=0, hwm=0, in_ready=1 immediately. The next push appears one cycle later.
REQ-036 Stall stability: out_valid high, out_ready low for 5 cycles while upstream keeps pushing -> out_data/out_bank_id/out_rob_id unchanged for all 5 cycles.
